// File: rtl/alu_pkg.sv
// Shared ALU datapath constants: slice width, add/sub op encoding and slice-count helper.
package alu_pkg;

  localparam int unsigned SLICE_W = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int unsigned slice_count(input int unsigned width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/cla_slice16.sv
// Combinational 16-bit carry-lookahead slice: four 4-bit groups joined by a
// second-level group P/G lookahead.
module cla_slice16
  import alu_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               c_in,
  output logic [SLICE_W-1:0] sum,
  output logic               c_out
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [3:0]         gp;
  logic [3:0]         gg;
  logic [3:0]         gc;

  assign p = a ^ b;
  assign g = a & b;

  // Group propagate/generate for each 4-bit group
  always_comb begin
    gp = '0;
    gg = '0;
    for (int j = 0; j < 4; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
  end

  assign gc[0] = c_in;
  assign gc[1] = gg[0] | (gp[0] & c_in);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & c_in);
  assign c_out = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & c_in);

  // Bit sums inside each group from the lookahead group carry
  always_comb begin : b_sum
    logic c;
    sum = '0;
    c   = 1'b0;
    for (int j = 0; j < 4; j++) begin
      c = gc[j];
      for (int i = 0; i < 4; i++) begin
        sum[4*j+i] = p[4*j+i] ^ c;
        c          = g[4*j+i] | (p[4*j+i] & c);
      end
    end
  end

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined CLA adder/subtractor, one 16-bit slice per stage, valid/ready backpressure.
// Optional ADDSUB_SAT_EN: clamp the result to signed max/min on overflow.
module cla_addsub_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned SW     = SLICE_W;
  localparam int unsigned NSLICE = slice_count(WIDTH);

  logic             adv;
  logic [WIDTH-1:0] bp;
  logic             last_v;
  logic             last_c;
  logic             last_ovf;
  logic [WIDTH-1:0] last_sum;

  // Single global advance: the whole pipe moves unless the result is stalled
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign bp       = (sub == OP_SUB) ? ~b : b;

  for (genvar k = 0; k < NSLICE; k++) begin : g_stage
    logic [SW-1:0] sa;
    logic [SW-1:0] sb;
    logic [SW-1:0] so;
    logic          ci;
    logic          vi;
    logic          co;

    if (k == 0) begin : g_src
      assign sa = a[SW-1:0];
      assign sb = bp[SW-1:0];
      assign ci = sub;
      assign vi = in_valid;
    end else begin : g_src
      assign sa = g_stage[k-1].g_mid.a_q[SW-1:0];
      assign sb = g_stage[k-1].g_mid.b_q[SW-1:0];
      assign ci = g_stage[k-1].g_mid.c_q;
      assign vi = g_stage[k-1].g_mid.v_q;
    end

    cla_slice16 u_slice (
      .a     (sa),
      .b     (sb),
      .c_in  (ci),
      .sum   (so),
      .c_out (co)
    );

    if (k < NSLICE - 1) begin : g_mid
      // Unconsumed operand slices ride above, finished sum slices below
      localparam int unsigned LO = (k + 1) * SW;
      localparam int unsigned UW = WIDTH - LO;

      logic [UW-1:0] a_q;
      logic [UW-1:0] b_q;
      logic [LO-1:0] s_q;
      logic          c_q;
      logic          v_q;
      logic [UW-1:0] a_up;
      logic [UW-1:0] b_up;
      logic [LO-1:0] s_lo;

      if (k == 0) begin : g_up
        assign a_up = a[WIDTH-1:SW];
        assign b_up = bp[WIDTH-1:SW];
        assign s_lo = so;
      end else begin : g_up
        assign a_up = g_stage[k-1].g_mid.a_q[UW+SW-1:SW];
        assign b_up = g_stage[k-1].g_mid.b_q[UW+SW-1:SW];
        assign s_lo = {so, g_stage[k-1].g_mid.s_q};
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v_q <= 1'b0;
        end else if (adv) begin
          v_q <= vi;
          c_q <= co;
          a_q <= a_up;
          b_q <= b_up;
          s_q <= s_lo;
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] raw;
      logic             ovf_raw;

      if (k == 0) begin : g_raw
        assign raw = so;
      end else begin : g_raw
        assign raw = {so, g_stage[k-1].g_mid.s_q};
      end

      // Operand MSBs are the top bits of the final slice inputs
      assign ovf_raw  = (sa[SW-1] == sb[SW-1]) & (raw[WIDTH-1] != sa[SW-1]);
      assign last_v   = vi;
      assign last_c   = co;
      assign last_ovf = ovf_raw;
`ifdef ADDSUB_SAT_EN
      // On overflow the true sign equals the operands' common sign
      assign last_sum = ovf_raw ? {sa[SW-1], {(WIDTH-1){~sa[SW-1]}}} : raw;
`else
      assign last_sum = raw;
`endif
    end
  end

  // Result register doubles as the final pipeline stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= last_v;
      sum       <= last_sum;
      c_out     <= last_c;
      ovf       <= last_ovf;
    end
  end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe (WIDTH=32): directed vector table,
// reset mid-stream, stalled stream and a randomized handshake stream.
module tb_cla_addsub_pipe;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned NSLICE = WIDTH / 16;
`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  cla_addsub_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        o;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sat_adj(input logic [31:0] s, input logic o, input logic amsb);
    logic [31:0] r;
    r = s;
    if (SAT && o) r = amsb ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return r;
  endfunction

  // Golden model returns {ovf, c_out, sum}
  function automatic logic [33:0] model(input logic [31:0] a_i, input logic [31:0] b_i,
                                        input logic sub_i);
    logic [31:0] bx;
    logic [32:0] t;
    logic        o;
    bx = sub_i ? ~b_i : b_i;
    t  = {1'b0, a_i} + {1'b0, bx} + 33'(sub_i);
    o  = (a_i[31] == bx[31]) && (t[31] != a_i[31]);
    return {o, t[32], sat_adj(t[31:0], o, a_i[31])};
  endfunction

  task automatic run_stream(input int n, input bit rnd, input string tag);
    logic [33:0] exp_q[$];
    logic [33:0] e;
    logic [31:0] held_sum;
    bit          was_held;
    bit          acc;
    int          sent;
    int          got;
    int          cyc;
    sent     = 0;
    got      = 0;
    cyc      = 0;
    was_held = 1'b0;
    held_sum = '0;
    in_valid = 1'b0;
    while (got < n && cyc < 3000) begin
      if (!in_valid && sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
        if (rnd) begin
          a   = $urandom;
          b   = $urandom;
          sub = 1'($urandom_range(0, 1));
        end else begin
          a   = 32'h0001_0000 * 32'(sent) + 32'h0000_FFFF;
          b   = 32'(sent + 1);
          sub = 1'(sent % 2);
        end
        in_valid = 1'b1;
      end
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 4 && cyc <= 6);
      #1;
      if (was_held) check({tag, "_hold_sum"}, 64'(sum), 64'(held_sum));
      if (out_valid && !out_ready) check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      was_held = out_valid && !out_ready;
      held_sum = sum;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check({tag, "_spurious_result"}, 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check({tag, "_sum"}, 64'(sum), 64'(e[31:0]));
          check({tag, "_c_out"}, 64'(c_out), 64'(e[32]));
          check({tag, "_ovf"}, 64'(ovf), 64'(e[33]));
        end
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back(model(a, b, sub));
        sent++;
      end
      @(posedge clk);
      #1;
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_result_count"}, 64'(got), 64'(n));
    check({tag, "_leftover"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int lat;
    int seen;

    vecs[0]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    vecs[1]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[2]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[4]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    vecs[6]  = '{32'h0000_000A, 32'h0000_0003, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
    vecs[7]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[8]  = '{32'hFFFF_0000, 32'h0001_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[10] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
    vecs[11] = '{32'h0000_FFFF, 32'hFFFF_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_c_out", 64'(c_out), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed table, one op at a time, latency measured from the accept edge
    for (int i = 0; i < 12; i++) begin
      a        = vecs[i].a;
      b        = vecs[i].b;
      sub      = vecs[i].sub;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(NSLICE));
      check($sformatf("vec%0d_sum", i), 64'(sum),
            64'(sat_adj(vecs[i].s, vecs[i].o, vecs[i].a[31])));
      check($sformatf("vec%0d_c_out", i), 64'(c_out), 64'(vecs[i].c));
      check($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vecs[i].o));
    end
    @(posedge clk);
    #1;

    // Reset with ops in flight: nothing must emerge afterwards
    a        = 32'h0000_0001;
    b        = 32'h0000_0002;
    sub      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = 32'h0000_0003;
    b = 32'h0000_0004;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("midrst_stale_results", 64'(seen), 64'd0);

    run_stream(8, 1'b0, "burst");
    run_stream(300, 1'b1, "rand");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
